// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
//   - CLK_HZ and default timing constants for a 100 MHz system clock
//   - per-channel repeat FSM state type
//   - max_u helper used to size the shared repeat counter
package btn_pkg;

    localparam int unsigned CLK_HZ              = 100_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;  // 20 ms
    localparam int unsigned HOLD_CYCLES_DEF     = CLK_HZ / 2;   // 500 ms
    localparam int unsigned REPEAT_CYCLES_DEF   = CLK_HZ / 10;  // 100 ms

    typedef enum logic [1:0] {
        StReleased,
        StHeldInit,
        StHeldRpt
    } btn_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, and
// press/auto-repeat FSM producing a registered single-cycle pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_raw      : raw bouncing button input (1 = pressed)
//   o_level    : debounced level
//   o_pulse    : one-cycle press / repeat event
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DW-1:0] DEB_TERM  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_TERM = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_TERM  = RW'(REPEAT_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_channel: DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("btn_channel: HOLD_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("btn_channel: REPEAT_CYCLES must be >= 2");
    end

    logic          r_s1, r_s2;
    logic          r_level;
    logic [DW-1:0] r_deb_cnt;
    logic [RW-1:0] r_rpt_cnt;
    btn_state_e    r_state;
    logic          r_pulse;

    logic          w_flip, w_rise, w_fall;
    logic          w_level_d;
    logic [DW-1:0] w_deb_cnt_d;
    logic [RW-1:0] w_rpt_cnt_d;
    btn_state_e    w_state_d;
    logic          w_pulse_d;

    // Debounce: level flips only after s2 has differed for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the current level restarts the count.
    always_comb begin
        w_flip      = (r_s2 != r_level) && (r_deb_cnt == DEB_TERM);
        w_rise      = w_flip && r_s2;
        w_fall      = w_flip && !r_s2;
        w_level_d   = w_flip ? r_s2 : r_level;
        w_deb_cnt_d = '0;
        if ((r_s2 != r_level) && !w_flip) begin
            w_deb_cnt_d = r_deb_cnt + 1'b1;
        end
    end

    // Repeat FSM runs off the next-level events so the press pulse lands in
    // the same cycle the debounced level first reads 1.
    always_comb begin
        w_state_d   = r_state;
        w_rpt_cnt_d = r_rpt_cnt;
        w_pulse_d   = 1'b0;
        if (w_fall) begin
            // Release wins over a same-cycle repeat terminal count.
            w_state_d   = StReleased;
            w_rpt_cnt_d = '0;
        end else begin
            unique case (r_state)
                StReleased: begin
                    if (w_rise) begin
                        w_pulse_d   = 1'b1;
                        w_rpt_cnt_d = '0;
                        w_state_d   = StHeldInit;
                    end
                end
                StHeldInit: begin
                    if (REPEAT_EN) begin
                        if (r_rpt_cnt == HOLD_TERM) begin
                            w_pulse_d   = 1'b1;
                            w_rpt_cnt_d = '0;
                            w_state_d   = StHeldRpt;
                        end else begin
                            w_rpt_cnt_d = r_rpt_cnt + 1'b1;
                        end
                    end
                end
                StHeldRpt: begin
                    if (r_rpt_cnt == RPT_TERM) begin
                        w_pulse_d   = 1'b1;
                        w_rpt_cnt_d = '0;
                    end else begin
                        w_rpt_cnt_d = r_rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_d   = StReleased;
                    w_rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
            r_rpt_cnt <= '0;
            r_state   <= StReleased;
            r_pulse   <= 1'b0;
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            r_level   <= w_level_d;
            r_deb_cnt <= w_deb_cnt_d;
            r_rpt_cnt <= w_rpt_cnt_d;
            r_state   <= w_state_d;
            r_pulse   <= w_pulse_d;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: N_BTN independent btn_channel
// instances whose outputs are concatenated.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw button pins (1 = pressed)
//   btn_level  : debounced level per channel
//   btn_pulse  : one-cycle press/repeat event per channel
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[i]),
            .o_level(btn_level[i]),
            .o_pulse(btn_pulse[i])
        );
    end

endmodule
